// File: rtl/reg_file_mp.sv
// reg_file_mp: 2-write/2-read register file with hardwired zero register and bulk-clear sequencer; define REGFILE_BYPASS_EN for read-during-write forwarding
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] R_Addr_A,
    input  logic [ADDR_W-1:0] R_Addr_B,
    output logic [DATA_W-1:0] R_Data_A,
    output logic [DATA_W-1:0] R_Data_B,
    input  logic              Write_Reg0,
    input  logic [ADDR_W-1:0] W_Addr0,
    input  logic [DATA_W-1:0] W_Data0,
    input  logic              Write_Reg1,
    input  logic [ADDR_W-1:0] W_Addr1,
    input  logic [DATA_W-1:0] W_Data1,
    input  logic              Clr_Req,
    output logic              Busy,
    output logic              Clr_Done
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                we0;
    logic                we1;

    assign we0      = Write_Reg0 && state_q == IDLE && !(ZERO_REG && W_Addr0 == '0);
    assign we1      = Write_Reg1 && state_q == IDLE && !(ZERO_REG && W_Addr1 == '0);
    assign Busy     = busy_q;
    assign Clr_Done = done_q;

    // Clear sequencer: walks the counter over every entry, then pulses done
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (Clr_Req) begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    // Storage: reset wipes all, clear wipes one entry per cycle, otherwise port 1 wins on a collision
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (we0) mem_q[W_Addr0] <= W_Data0;
            if (we1) mem_q[W_Addr1] <= W_Data1;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Read ports with same-cycle forwarding of committing writes, port 1 first
    always_comb begin
        R_Data_A = (ZERO_REG && R_Addr_A == '0) ? '0 :
                   (we1 && W_Addr1 == R_Addr_A) ? W_Data1 :
                   (we0 && W_Addr0 == R_Addr_A) ? W_Data0 : mem_q[R_Addr_A];
        R_Data_B = (ZERO_REG && R_Addr_B == '0) ? '0 :
                   (we1 && W_Addr1 == R_Addr_B) ? W_Data1 :
                   (we0 && W_Addr0 == R_Addr_B) ? W_Data0 : mem_q[R_Addr_B];
    end
`else
    // Read ports straight from the array; zero register forced to 0
    always_comb begin
        R_Data_A = (ZERO_REG && R_Addr_A == '0) ? '0 : mem_q[R_Addr_A];
        R_Data_B = (ZERO_REG && R_Addr_B == '0) ? '0 : mem_q[R_Addr_B];
    end
`endif
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed and random checks of reg_file_mp against a timeline-based reference model
module tb_reg_file_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ra, rb, wa0, wa1;
    logic [DW-1:0] rda, rdb, wd0, wd1;
    logic          we0, we1, clr, busy, done;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut (
        .Clk(clk), .Reset(rst),
        .R_Addr_A(ra), .R_Addr_B(rb), .R_Data_A(rda), .R_Data_B(rdb),
        .Write_Reg0(we0), .W_Addr0(wa0), .W_Data0(wd0),
        .Write_Reg1(we1), .W_Addr1(wa1), .W_Data1(wd1),
        .Clr_Req(clr), .Busy(busy), .Clr_Done(done)
    );

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] m [D];
    bit            mbusy = 0;
    bit            mdone = 0;
    int            edge_no = 0;
    int            n0 = 0;
    int            busy_cnt, done_cnt;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = m[a];
`ifdef REGFILE_BYPASS_EN
        if (!mbusy) begin
            if (we0 && wa0 == a) v = wd0;
            if (we1 && wa1 == a) v = wd1;
        end
`endif
        return v;
    endfunction

    // Reference: a clear requested at edge n zeroes entry k at edge n+1+k and finishes at n+D
    task automatic model_edge();
        int k;
        edge_no++;
        if (rst) begin
            foreach (m[i]) m[i] = '0;
            mbusy = 0;
            mdone = 0;
        end else if (!mbusy) begin
            if (we0 && wa0 != 0) m[wa0] = wd0;
            if (we1 && wa1 != 0) m[wa1] = wd1;
            mdone = 0;
            if (clr) begin
                mbusy = 1;
                n0 = edge_no;
            end
        end else begin
            k = edge_no - n0 - 1;
            m[k] = '0;
            mdone = (k == D - 1);
            if (mdone) mbusy = 0;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check("rd_a", rda, exp_rd(ra));
        check("rd_b", rdb, exp_rd(rb));
        @(posedge clk);
        model_edge();
        #1;
        check("busy", {31'b0, busy}, {31'b0, mbusy});
        check("done", {31'b0, done}, {31'b0, mdone});
    endtask

    task automatic idle_inputs();
        we0 = 0; we1 = 0; clr = 0; rst = 0;
    endtask

    initial begin
        foreach (m[i]) m[i] = '0;
        rst = 1; ra = 0; rb = 0; we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; clr = 0;
        cyc();
        cyc();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        rst = 0;
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF;
        cyc();
        idle_inputs(); ra = 5; rb = 0;
        #1;
        check("t1_r5", rda, 32'hDEADBEEF);
        check("t1_r0", rdb, 32'h0);
        cyc();
        we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22;
        cyc();
        we0 = 1; wa0 = 0; wd0 = 32'hFFFF; we1 = 0;
        cyc();
        idle_inputs(); ra = 7; rb = 0;
        #1;
        check("t2_r7", rda, 32'h22);
        check("t2_r0", rdb, 32'h0);
        for (int i = 1; i < D; i += 2) begin
            we0 = 1; wa0 = AW'(i); wd0 = DW'(i);
            we1 = (i + 1 < D); wa1 = AW'(i + 1); wd1 = DW'(i + 1);
            cyc();
        end
        idle_inputs(); ra = 3; rb = 31;
        #1;
        check("t3_r3_pre", rda, 32'd3);
        clr = 1;
        cyc();
        clr = 0;
        busy_cnt = busy; done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 5) begin we0 = 1; wa0 = 9; wd0 = 32'h55; end
            if (c == 6) begin we0 = 0; clr = 1; end
            if (c == 7) clr = 0;
            cyc();
            busy_cnt += busy;
            done_cnt += done;
        end
        check("t3_busy_len", busy_cnt, 32'd32);
        check("t3_done_cnt", done_cnt, 32'd1);
        ra = 9; rb = 3;
        #1;
        check("t4_r9", rda, 32'h0);
        check("t4_r3", rdb, 32'h0);
        for (int i = 1; i < D; i++) begin
            we0 = 1; wa0 = AW'(i); wd0 = 32'hA000 + DW'(i);
            cyc();
        end
        idle_inputs();
        clr = 1;
        cyc();
        clr = 0;
        for (int c = 0; c < 10; c++) cyc();
        rst = 1;
        cyc();
        rst = 0;
        check("t5_busy", {31'b0, busy}, 32'd0);
        check("t5_done", {31'b0, done}, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < D; i++) begin
            ra = AW'(i); rb = AW'(D - 1 - i);
            cyc();
            done_cnt += done;
        end
        check("t5_no_done", done_cnt, 32'd0);
        we0 = 1; wa0 = 4; wd0 = 32'hA5A5; ra = 4;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("t6_same", rda, 32'hA5A5);
`else
        check("t6_same", rda, 32'h0);
`endif
        cyc();
        idle_inputs();
        #1;
        check("t6_next", rda, 32'hA5A5);
        for (int c = 0; c < 2500; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            clr = ($urandom_range(0, 79) == 0);
            we0 = $urandom_range(0, 1); wa0 = AW'($urandom); wd0 = $urandom;
            we1 = $urandom_range(0, 1); wa1 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom); wd1 = $urandom;
            ra = ($urandom_range(0, 2) == 0) ? wa1 : AW'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? wa0 : AW'($urandom);
            cyc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
